// File: rtl/trap_csr_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : trap_csr_unit_pkg
// Brief  : Shared types, CSR addresses and helpers for the M-mode trap/CSR unit
// Rev    : 1.0  initial release
// ============================================================================
package trap_csr_unit_pkg;

  typedef enum logic [1:0] {
    CSR_RW   = 2'd0,
    CSR_RS   = 2'd1,
    CSR_RC   = 2'd2,
    CSR_NONE = 2'd3
  } csrOp_;

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    TRAP_ENTER = 1'b1
  } trapState_;

  localparam logic [11:0] c_CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] c_CSR_MTVEC     = 12'h305;
  localparam logic [11:0] c_CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_CSR_MEPC      = 12'h341;
  localparam logic [11:0] c_CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] c_CSR_MTVAL     = 12'h343;
  localparam logic [11:0] c_CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] c_CSR_MINSTRETH = 12'hB82;

  localparam int c_MSTATUS_MIE  = 3;
  localparam int c_MSTATUS_MPIE = 7;

  function automatic logic [31:0] csrModify(input csrOp_ op, input logic [31:0] oldValue,
                                            input logic [31:0] writeData);
    logic [31:0] result;
    result = oldValue;
    case (op)
      CSR_RW:  result = writeData;
      CSR_RS:  result = oldValue | writeData;
      CSR_RC:  result = oldValue & ~writeData;
      default: result = oldValue;
    endcase
    return result;
  endfunction

endpackage : trap_csr_unit_pkg
`default_nettype wire

// File: rtl/trap_csr_unit_counter64.sv
`default_nettype none
// ============================================================================
// Module : csr_counter64
// Brief  : 64-bit counter with per-half CSR write ports; a written half skips
//          its own increment, the carry into the high half uses the old low half
// Rev    : 1.0  initial release
// ============================================================================
module csr_counter64 (
  input  logic        clock,
  input  logic        reset,
  input  logic        incEnable,
  input  logic        writeLo,
  input  logic        writeHi,
  input  logic [31:0] writeData,
  output logic [63:0] count
);

  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic        w_carry;

  assign w_carry = incEnable && (r_lo == 32'hFFFF_FFFF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lo <= '0;
      r_hi <= '0;
    end else begin
      r_lo <= writeLo ? writeData : (r_lo + {31'b0, incEnable});
      r_hi <= writeHi ? writeData : (r_hi + {31'b0, w_carry});
    end
  end

  assign count = {r_hi, r_lo};

endmodule : csr_counter64
`default_nettype wire

// File: rtl/trap_csr_unit.sv
`default_nettype none
// ============================================================================
// Module : trap_csr_unit
// Brief  : Machine-mode trap entry, MRET, Zicsr access and mcycle/minstret
// Rev    : 1.0  initial release
// ============================================================================
module trap_csr_unit
  import trap_csr_unit_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
  parameter bit          ENABLE_COUNTERS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trapRequest,
  input  logic [3:0]  trapCause,
  input  logic [31:0] trapPc,
  input  logic [31:0] trapValue,
  input  logic        mretValid,
  input  logic        csrValid,
  input  csrOp_       csrOp,
  input  logic [11:0] csrAddress,
  input  logic [31:0] csrWriteData,
  input  logic        retireValid,
  output logic [31:0] csrReadData,
  output logic        csrIllegal,
  output logic        redirectValid,
  output logic [31:0] redirectTarget,
  output logic        trapBusy
);

  trapState_   r_state, w_stateNext;
  logic [31:0] r_mepc, r_mcause, r_mtval, r_mscratch, r_mtvec;
  logic        r_mie, r_mpie;
  logic [31:0] w_mepcNext, w_mcauseNext, w_mtvalNext, w_mscratchNext, w_mtvecNext;
  logic        w_mieNext, w_mpieNext;
  logic [63:0] w_mcycle, w_minstret;
  logic [31:0] w_mstatus, w_newValue;
  logic        w_idle, w_csrWrite, w_trapTake, w_mretTake;

  assign w_idle     = (r_state == IDLE);
  assign w_trapTake = w_idle && trapRequest;
  assign w_mretTake = w_idle && mretValid && !trapRequest;

  // MPP is hardwired to machine mode; only MIE/MPIE are storage.
  always_comb begin
    w_mstatus                 = 32'h0000_1800;
    w_mstatus[c_MSTATUS_MIE]  = r_mie;
    w_mstatus[c_MSTATUS_MPIE] = r_mpie;
  end

  always_comb begin
    csrReadData = '0;
    csrIllegal  = 1'b0;
    case (csrAddress)
      c_CSR_MSTATUS:   csrReadData = w_mstatus;
      c_CSR_MTVEC:     csrReadData = r_mtvec;
      c_CSR_MSCRATCH:  csrReadData = r_mscratch;
      c_CSR_MEPC:      csrReadData = r_mepc;
      c_CSR_MCAUSE:    csrReadData = r_mcause;
      c_CSR_MTVAL:     csrReadData = r_mtval;
      c_CSR_MCYCLE:    csrReadData = w_mcycle[31:0];
      c_CSR_MCYCLEH:   csrReadData = w_mcycle[63:32];
      c_CSR_MINSTRET:  csrReadData = w_minstret[31:0];
      c_CSR_MINSTRETH: csrReadData = w_minstret[63:32];
      default:         csrIllegal  = 1'b1;
    endcase
  end

  assign w_newValue = csrModify(csrOp, csrReadData, csrWriteData);
  assign w_csrWrite = w_idle && csrValid && (csrOp != CSR_NONE) && !csrIllegal;

  // CSR write lands first; trap or MRET fields then override the same registers.
  always_comb begin
    w_mepcNext     = r_mepc;
    w_mcauseNext   = r_mcause;
    w_mtvalNext    = r_mtval;
    w_mscratchNext = r_mscratch;
    w_mtvecNext    = r_mtvec;
    w_mieNext      = r_mie;
    w_mpieNext     = r_mpie;
    if (w_csrWrite) begin
      case (csrAddress)
        c_CSR_MSTATUS: begin
          w_mieNext  = w_newValue[c_MSTATUS_MIE];
          w_mpieNext = w_newValue[c_MSTATUS_MPIE];
        end
        c_CSR_MTVEC:    w_mtvecNext    = {w_newValue[31:2], 2'b00};
        c_CSR_MSCRATCH: w_mscratchNext = w_newValue;
        c_CSR_MEPC:     w_mepcNext     = {w_newValue[31:2], 2'b00};
        c_CSR_MCAUSE:   w_mcauseNext   = w_newValue;
        c_CSR_MTVAL:    w_mtvalNext    = w_newValue;
        default: ;
      endcase
    end
    if (w_trapTake) begin
      w_mepcNext   = {trapPc[31:2], 2'b00};
      w_mcauseNext = {28'b0, trapCause};
      w_mtvalNext  = trapValue;
      w_mpieNext   = w_mieNext;
      w_mieNext    = 1'b0;
    end else if (w_mretTake) begin
      w_mieNext  = w_mpieNext;
      w_mpieNext = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_mscratch <= '0;
      r_mtvec    <= MTVEC_RESET;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
    end else begin
      r_mepc     <= w_mepcNext;
      r_mcause   <= w_mcauseNext;
      r_mtval    <= w_mtvalNext;
      r_mscratch <= w_mscratchNext;
      r_mtvec    <= w_mtvecNext;
      r_mie      <= w_mieNext;
      r_mpie     <= w_mpieNext;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext    = r_state;
    redirectValid  = 1'b0;
    redirectTarget = r_mepc;
    trapBusy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (trapRequest) begin
          w_stateNext = TRAP_ENTER;
        end else if (mretValid) begin
          redirectValid  = 1'b1;
          redirectTarget = r_mepc;
        end
      end
      TRAP_ENTER: begin
        w_stateNext    = IDLE;
        redirectValid  = 1'b1;
        redirectTarget = r_mtvec;
        trapBusy       = 1'b1;
      end
    endcase
    // Keep the strobe quiet while reset is held, even if mretValid is asserted.
    if (reset) begin
      redirectValid = 1'b0;
      trapBusy      = 1'b0;
    end
  end

  generate
    if (ENABLE_COUNTERS) begin : g_counters
      csr_counter64 u_mcycle (
        .clock     (clock),
        .reset     (reset),
        .incEnable (1'b1),
        .writeLo   (w_csrWrite && (csrAddress == c_CSR_MCYCLE)),
        .writeHi   (w_csrWrite && (csrAddress == c_CSR_MCYCLEH)),
        .writeData (w_newValue),
        .count     (w_mcycle)
      );
      csr_counter64 u_minstret (
        .clock     (clock),
        .reset     (reset),
        .incEnable (retireValid),
        .writeLo   (w_csrWrite && (csrAddress == c_CSR_MINSTRET)),
        .writeHi   (w_csrWrite && (csrAddress == c_CSR_MINSTRETH)),
        .writeData (w_newValue),
        .count     (w_minstret)
      );
    end else begin : g_noCounters
      assign w_mcycle   = '0;
      assign w_minstret = '0;
    end
  endgenerate

endmodule : trap_csr_unit
`default_nettype wire

// File: tb/tb_trap_csr_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_trap_csr_unit
// Brief  : Scoreboard bench for trap_csr_unit against an architectural model
// Rev    : 1.0  initial release
// ============================================================================
module tb_trap_csr_unit;
  import trap_csr_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        trapRequest, mretValid, csrValid, retireValid;
  logic [3:0]  trapCause;
  logic [31:0] trapPc, trapValue, csrWriteData;
  csrOp_       csrOp;
  logic [11:0] csrAddress;
  logic [31:0] csrReadData, redirectTarget;
  logic        csrIllegal, redirectValid, trapBusy;

  trap_csr_unit #(.MTVEC_RESET(32'h100), .ENABLE_COUNTERS(1'b1)) dut (
    .clock(clock), .reset(reset), .trapRequest(trapRequest), .trapCause(trapCause),
    .trapPc(trapPc), .trapValue(trapValue), .mretValid(mretValid), .csrValid(csrValid),
    .csrOp(csrOp), .csrAddress(csrAddress), .csrWriteData(csrWriteData),
    .retireValid(retireValid), .csrReadData(csrReadData), .csrIllegal(csrIllegal),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget), .trapBusy(trapBusy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rd;
    logic        ill;
    logic        rv;
    logic [31:0] rt;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Architectural model state
  logic [31:0] mMepc, mMcause, mMtval, mMscratch, mMtvec;
  logic        mMie, mMpie, mTrap;
  logic [63:0] mCycle, mInstret;

  function automatic void modelReset();
    mMepc = 0; mMcause = 0; mMtval = 0; mMscratch = 0; mMtvec = 32'h100;
    mMie = 0; mMpie = 0; mTrap = 0; mCycle = 0; mInstret = 0;
  endfunction

  function automatic logic [31:0] mRead(input logic [11:0] a, output logic ill);
    ill = 1'b0;
    case (a)
      12'h300: return 32'h1800 | (32'(mMpie) << 7) | (32'(mMie) << 3);
      12'h305: return mMtvec;
      12'h340: return mMscratch;
      12'h341: return mMepc;
      12'h342: return mMcause;
      12'h343: return mMtval;
      12'hB00: return mCycle[31:0];
      12'hB80: return mCycle[63:32];
      12'hB02: return mInstret[31:0];
      12'hB82: return mInstret[63:32];
      default: begin ill = 1'b1; return 32'h0; end
    endcase
  endfunction

  // 64-bit counter step: a written half takes the new value, the other half follows
  // ordinary +inc arithmetic computed from the old 64-bit value.
  function automatic logic [63:0] cntStep(input logic [63:0] c, input logic inc,
                                          input logic wLo, input logic wHi, input logic [31:0] v);
    logic [63:0] s;
    s = c + 64'(inc);
    if (wLo) s[31:0] = v;
    if (wHi) s[63:32] = v;
    return s;
  endfunction

  task automatic modelStep();
    logic [31:0] old, nv;
    logic        ill, doW;
    if (reset) begin modelReset(); return; end
    if (mTrap) begin
      mTrap = 0;
      mCycle = mCycle + 1;
      mInstret = mInstret + 64'(retireValid);
      return;
    end
    old = mRead(csrAddress, ill);
    doW = csrValid && (csrOp != CSR_NONE) && !ill;
    case (csrOp)
      CSR_RW:  nv = csrWriteData;
      CSR_RS:  nv = old | csrWriteData;
      default: nv = old & ~csrWriteData;
    endcase
    mCycle = cntStep(mCycle, 1'b1, doW && csrAddress == 12'hB00, doW && csrAddress == 12'hB80, nv);
    mInstret = cntStep(mInstret, retireValid, doW && csrAddress == 12'hB02,
                       doW && csrAddress == 12'hB82, nv);
    if (doW) begin
      case (csrAddress)
        12'h300: begin mMie = nv[3]; mMpie = nv[7]; end
        12'h305: mMtvec = nv & ~32'h3;
        12'h340: mMscratch = nv;
        12'h341: mMepc = nv & ~32'h3;
        12'h342: mMcause = nv;
        12'h343: mMtval = nv;
        default: ;
      endcase
    end
    if (trapRequest) begin
      mMepc = trapPc & ~32'h3; mMcause = 32'(trapCause); mMtval = trapValue;
      mMpie = mMie; mMie = 0; mTrap = 1;
    end else if (mretValid) begin
      mMie = mMpie; mMpie = 1;
    end
  endtask

  task automatic tick();
    exp_t e;
    if (reset) modelReset();
    e.rd   = mRead(csrAddress, e.ill);
    e.busy = !reset && mTrap;
    e.rv   = !reset && (mTrap || (mretValid && !trapRequest));
    e.rt   = mTrap ? mMtvec : mMepc;
    sb.push_back(e);
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compared mid-cycle
  always @(negedge clock) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("csrReadData", csrReadData, e.rd);
      check("csrIllegal", 32'(csrIllegal), 32'(e.ill));
      check("redirectValid", 32'(redirectValid), 32'(e.rv));
      check("trapBusy", 32'(trapBusy), 32'(e.busy));
      if (e.rv) check("redirectTarget", redirectTarget, e.rt);
    end
  end

  task automatic setIdle();
    trapRequest = 0; trapCause = 0; trapPc = 0; trapValue = 0; mretValid = 0;
    csrValid = 0; csrOp = CSR_NONE; csrAddress = 12'h305; csrWriteData = 0; retireValid = 0;
  endtask

  task automatic csrDo(input csrOp_ op, input logic [11:0] a, input logic [31:0] d);
    setIdle(); csrValid = 1; csrOp = op; csrAddress = a; csrWriteData = d; tick();
  endtask

  task automatic readAt(input logic [11:0] a);
    setIdle(); csrAddress = a; tick();
  endtask

  task automatic trapAt(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tv);
    setIdle(); trapRequest = 1; trapCause = c; trapPc = pc; trapValue = tv; tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  logic [11:0] addrList [12];
  initial begin
    addrList = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h344};
    reset = 1; setIdle(); modelReset();
    @(posedge clock); #1;

    // Reset cycle: mtvec reset value visible, MRET strobe suppressed
    mretValid = 1; tick(); tick();
    reset = 0; readAt(12'h305);

    // Trap entry with mtvec low bits masked
    csrDo(CSR_RW, 12'h305, 32'h8000_0003);
    trapAt(4'd2, 32'h40, 32'h73);
    readAt(12'h341);
    readAt(12'h342); readAt(12'h343); readAt(12'h300);

    // MIE set, trap, then MRET back to mepc
    csrDo(CSR_RS, 12'h300, 32'h8);
    trapAt(4'd3, 32'h44, 32'h0);
    readAt(12'h300);
    setIdle(); mretValid = 1; csrAddress = 12'h341; tick();
    readAt(12'h300);

    // Trap overrides a same-cycle CSR write to mepc
    setIdle(); trapRequest = 1; trapCause = 4'd4; trapPc = 32'h80; trapValue = 32'h1000;
    csrValid = 1; csrOp = CSR_RW; csrAddress = 12'h341; csrWriteData = 32'h1234; tick();
    readAt(12'h341); readAt(12'h342);

    // mcycle low-half carry, then RS of zero leaves minstret unchanged
    csrDo(CSR_RW, 12'hB80, 32'h0);
    csrDo(CSR_RW, 12'hB00, 32'hFFFF_FFFF);
    readAt(12'hB00); readAt(12'hB80); readAt(12'hB00);
    setIdle(); retireValid = 1; tick(); tick();
    csrDo(CSR_RS, 12'hB02, 32'h0);
    readAt(12'hB02);

    // Unimplemented address
    csrDo(CSR_RW, 12'h7C0, 32'hDEAD_BEEF);
    readAt(12'h340);

    // Reset while in TRAP_ENTER: no redirect
    trapAt(4'd6, 32'h200, 32'h300);
    reset = 1; readAt(12'h341);
    reset = 0; readAt(12'h341);

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      int r;
      setIdle();
      reset = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 11);
      trapRequest = (r == 0);
      mretValid   = (r == 1);
      trapCause = 4'($urandom); trapPc = $urandom; trapValue = $urandom;
      retireValid = 1'($urandom);
      csrAddress = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addrList[$urandom_range(0, 11)];
      csrValid = !mretValid && ($urandom_range(0, 1) == 1);
      csrOp = csrOp_'($urandom_range(0, 3));
      csrWriteData = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      tick();
    end
    reset = 0; setIdle(); tick();

    @(negedge clock); @(negedge clock);
    check("scoreboardDrained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_trap_csr_unit
`default_nettype wire
